exu_gpr_file: RTL and testbench

Integer general-purpose register file for the RV32I execute unit; the responder (slave) end of the `exu_gpr_if_t` interface driven by the EXU instruction handlers. It provides two combinational read ports and one synchronous write port. After reset it runs a sequenced clear of x1..x31. It also exposes a debug read port and a committed-write counter.

---
 rtl/exu_gpr_file_if.sv | 18 +
 rtl/exu_gpr_file.sv | 59 +++++
 tb/tb_exu_gpr_file.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/exu_gpr_file_if.sv
// rtl/exu_gpr_file_if.sv - EXU to GPR file read/write port bundle
interface exu_gpr_if_t #(
  parameter int RV_XLEN   = 32,
  parameter int RV_GPR_AW = 5
);
  logic [RV_GPR_AW-1:0] ra1;
  logic [RV_GPR_AW-1:0] ra2;
  logic [RV_XLEN-1:0]   rd1;
  logic [RV_XLEN-1:0]   rd2;
  logic                 wen;
  logic [RV_GPR_AW-1:0] wa;
  logic [RV_XLEN-1:0]   wd;

  // Instruction handlers drive addresses and write data.
  modport mst (output ra1, ra2, wen, wa, wd, input rd1, rd2);
  // Register file answers reads combinationally and captures writes.
  modport slv (input ra1, ra2, wen, wa, wd, output rd1, rd2);
endinterface

// File: rtl/exu_gpr_file.sv
// rtl/exu_gpr_file.sv - RV32I integer register file with post-reset clear
module exu_gpr_file #(
  parameter bit CLR_ON_RST = 1'b1,
  parameter int RV_XLEN    = 32,
  parameter int RV_GPR_AW  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  exu_gpr_if_t.slv             gpr_slv,
  input  logic [RV_GPR_AW-1:0] dbg_ra,
  output logic [RV_XLEN-1:0]   dbg_rd,
  output logic                 busy,
  output logic [31:0]          wr_cnt
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t               state;
  logic [4:0]           clr_idx;
  logic [RV_XLEN-1:0]   regs [1:31];

  // Sequencer: reset restarts the clear walk; the walk ends on the x31 write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLR_ON_RST ? S_CLEAR : S_RUN;
      clr_idx <= 5'd1;
      wr_cnt  <= 32'd0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_idx <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) state <= S_RUN;
        end
        default: begin
          if (gpr_slv.wen) wr_cnt <= wr_cnt + 32'd1;
        end
      endcase
    end
  end

  // Storage update: clear walk owns the array while clearing, master writes only in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        if (clr_idx != 5'd0) regs[clr_idx] <= '0;
      end else if (gpr_slv.wen && (gpr_slv.wa != '0)) begin
        regs[gpr_slv.wa] <= gpr_slv.wd;
      end
    end
  end

  assign busy = (state == S_CLEAR);

  // No write bypass: handlers build wd from rd1/rd2, so a bypass would close a loop.
  assign gpr_slv.rd1 = (busy || gpr_slv.ra1 == '0) ? '0 : regs[gpr_slv.ra1];
  assign gpr_slv.rd2 = (busy || gpr_slv.ra2 == '0) ? '0 : regs[gpr_slv.ra2];
  assign dbg_rd      = (busy || dbg_ra == '0)      ? '0 : regs[dbg_ra];

endmodule

// File: tb/tb_exu_gpr_file.sv
// tb/tb_exu_gpr_file.sv - self-checking bench for exu_gpr_file
module tb_exu_gpr_file;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  dbg_ra;
  logic [31:0] dbg_rd;
  logic        busy;
  logic [31:0] wr_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register values, clear cycles left, write count.
  logic [31:0] m_reg [0:31];
  int          m_clear_left;
  logic [31:0] m_cnt;

  exu_gpr_if_t gpr ();

  exu_gpr_file #(.CLR_ON_RST(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .gpr_slv (gpr.slv),
    .dbg_ra  (dbg_ra),
    .dbg_rd  (dbg_rd),
    .busy    (busy),
    .wr_cnt  (wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (m_clear_left > 0 || a == 5'd0) return 32'd0;
    return m_reg[a];
  endfunction

  // Compare combinational outputs against the model, then advance one edge.
  task automatic step();
    #1;
    chk("rd1", gpr.rd1, m_read(gpr.ra1));
    chk("rd2", gpr.rd2, m_read(gpr.ra2));
    chk("dbg_rd", dbg_rd, m_read(dbg_ra));
    chk("busy", {31'd0, busy}, {31'd0, m_clear_left > 0});
    chk("wr_cnt", wr_cnt, m_cnt);
    @(posedge clk);
    if (rst) begin
      m_clear_left = 31;
      m_cnt = 32'd0;
    end else if (m_clear_left > 0) begin
      m_reg[32 - m_clear_left] = 32'd0;
      m_clear_left--;
    end else if (gpr.wen) begin
      m_cnt = m_cnt + 32'd1;
      if (gpr.wa != 5'd0) m_reg[gpr.wa] = gpr.wd;
    end
    #1;
  endtask

  task automatic idle();
    gpr.wen = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    gpr.wen = 1'b1;
    gpr.wa  = a;
    gpr.wd  = d;
    step();
    gpr.wen = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_cnt = 32'd0;
    m_clear_left = 31;
    rst = 1'b1;
    gpr.wen = 1'b0; gpr.wa = 5'd0; gpr.wd = 32'd0;
    gpr.ra1 = 5'd5; gpr.ra2 = 5'd0; dbg_ra = 5'd5;
    @(posedge clk);
    #1;
    step();
    chk("reset_busy", {31'd0, busy}, 32'd1);
    chk("reset_cnt", wr_cnt, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 31; i++) step();
    chk("clear_done_busy", {31'd0, busy}, 32'd0);

    // Preload x5 and then pulse reset; count busy cycles and watch x5.
    wr(5'd5, 32'hDEAD_BEEF);
    #1;
    chk("preload_x5", dbg_rd, 32'hDEAD_BEEF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cycles++;
      chk("x5_during_clear", dbg_rd, 32'd0);
      step();
    end
    chk("busy_cycles", busy_cycles, 32'd31);
    chk("x5_after_clear", dbg_rd, 32'd0);
    chk("cnt_after_clear", wr_cnt, 32'd0);

    // Write x7: same-cycle read sees old value, next cycle sees new value.
    gpr.ra1 = 5'd7; gpr.ra2 = 5'd7; dbg_ra = 5'd7;
    gpr.wen = 1'b1; gpr.wa = 5'd7; gpr.wd = 32'h1234_5678;
    #1;
    chk("x7_same_cycle", gpr.rd1, 32'd0);
    step();
    idle();
    #1;
    chk("x7_rd1", gpr.rd1, 32'h1234_5678);
    chk("x7_rd2", gpr.rd2, 32'h1234_5678);
    chk("x7_dbg", dbg_rd, 32'h1234_5678);

    // x0 write is discarded but counted.
    gpr.ra1 = 5'd0;
    wr(5'd0, 32'hFFFF_FFFF);
    #1;
    chk("x0_read", gpr.rd1, 32'd0);
    chk("x0_cnt", wr_cnt, 32'd2);

    // addi x3,x3,1 ten times, wd taken from the live rd1.
    gpr.ra1 = 5'd3; dbg_ra = 5'd3;
    for (int i = 0; i < 10; i++) begin
      gpr.wen = 1'b1; gpr.wa = 5'd3;
      #1;
      gpr.wd = gpr.rd1 + 32'd1;
      step();
    end
    idle();
    #1;
    chk("rmw_x3", gpr.rd1, 32'd10);

    // Write during clear is ignored.
    rst = 1'b1;
    step();
    rst = 1'b0;
    dbg_ra = 5'd9;
    for (int i = 0; i < 31; i++) begin
      if (i == 4) begin
        gpr.wen = 1'b1; gpr.wa = 5'd9; gpr.wd = 32'hA5A5_A5A5;
      end else begin
        gpr.wen = 1'b0;
      end
      step();
    end
    #1;
    chk("x9_after_clear", dbg_rd, 32'd0);
    chk("cnt_clear_write", wr_cnt, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      gpr.ra1 = 5'($urandom_range(0, 31));
      gpr.ra2 = 5'($urandom_range(0, 31));
      dbg_ra  = 5'($urandom_range(0, 31));
      gpr.wen = ($urandom_range(0, 3) != 0);
      gpr.wa  = 5'($urandom_range(0, 31));
      gpr.wd  = $urandom;
      rst     = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) step();

    // Counter wrap.
    @(negedge clk);
    force dut.wr_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.wr_cnt;
    m_cnt = 32'hFFFF_FFFE;
    wr(5'd12, 32'h0000_0001);
    wr(5'd13, 32'h0000_0002);
    #1;
    chk("cnt_wrap", wr_cnt, 32'd0);

    // Reset with a simultaneous write: write dropped, clear restarts at x1.
    gpr.ra1 = 5'd1; dbg_ra = 5'd1;
    rst = 1'b1;
    wr(5'd1, 32'h5555_AAAA);
    rst = 1'b0;
    #1;
    chk("rst_wen_cnt", wr_cnt, 32'd0);
    chk("rst_wen_busy", {31'd0, busy}, 32'd1);
    busy_cycles = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cycles++;
      step();
    end
    chk("busy_cycles_2", busy_cycles, 32'd31);
    chk("x1_after_rst", gpr.rd1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
